// File: rtl/fft_sched_pkg.sv
// Shared types and default geometry for the FFT frame-buffer bank scheduler.
package fft_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

  localparam int NUM_MIC_DEF = 8;
  localparam int NUM_BIN_DEF = 256;
  localparam int MIC_W_DEF   = $clog2(NUM_MIC_DEF);
  localparam int BIN_W_DEF   = $clog2(NUM_BIN_DEF);
  localparam int TUSER_W_DEF = MIC_W_DEF + BIN_W_DEF;
  localparam int CPLX_W      = 64;

endpackage

// File: rtl/fft_bank_tracker.sv
// Ping-pong bank ownership: full flags, writer/reader bank pointers, overflow.
// Optional FFT_SCHED_STATS_EN adds released-frame and dropped-frame counters.
module fft_bank_tracker (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_frame_done,
  input  logic        rd_release,
  output logic        wr_bank,
  output logic        rd_bank,
  output logic [1:0]  full,
  output logic        wr_allow,
  output logic        overflow
`ifdef FFT_SCHED_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt
`endif
);

  logic [1:0] full_reg;
  logic [1:0] full_after_rel;
  logic [1:0] full_next;
  logic       wr_bank_reg;
  logic       rd_bank_reg;
  logic       overflow_reg;
  logic       accept;
  logic       frame_drop;

  // The reader's release lands before the writer's claim, so a frame that
  // completes on the same cycle its target bank is freed is not dropped.
  always_comb begin
    full_after_rel = full_reg;
    if (rd_release) begin
      full_after_rel[rd_bank_reg] = 1'b0;
    end
    accept    = wr_frame_done & ~full_after_rel[wr_bank_reg];
    full_next = full_after_rel;
    if (accept) begin
      full_next[wr_bank_reg] = 1'b1;
    end
  end

  assign frame_drop = wr_frame_done & ~accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_reg     <= 2'b00;
      wr_bank_reg  <= 1'b0;
      rd_bank_reg  <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      full_reg <= full_next;
      if (accept) begin
        wr_bank_reg <= ~wr_bank_reg;
      end
      if (rd_release) begin
        rd_bank_reg <= ~rd_bank_reg;
      end
      if (frame_drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign full     = full_reg;
  assign wr_bank  = wr_bank_reg;
  assign rd_bank  = rd_bank_reg;
  assign wr_allow = ~full_reg[wr_bank_reg];
  assign overflow = overflow_reg;

`ifdef FFT_SCHED_STATS_EN
  logic [15:0] frame_cnt_reg;
  logic [15:0] drop_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_reg <= 16'd0;
      drop_cnt_reg  <= 16'd0;
    end else begin
      if (rd_release) begin
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
      if (frame_drop && (drop_cnt_reg != 16'hFFFF)) begin
        drop_cnt_reg <= drop_cnt_reg + 16'd1;
      end
    end
  end

  assign frame_cnt = frame_cnt_reg;
  assign drop_cnt  = drop_cnt_reg;
`endif

endmodule

// File: rtl/fft_bank_scheduler.sv
// Streams completed FFT frame-buffer banks out of BRAM port B, bin-major, as AXIS.
// Optional FFT_SCHED_STATS_EN exposes frame_cnt / drop_cnt from the bank tracker.
module fft_bank_scheduler
  import fft_sched_pkg::*;
#(
  parameter int NUM_MIC = NUM_MIC_DEF,
  parameter int NUM_BIN = NUM_BIN_DEF,
  parameter int BANK_AW = 11
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    wr_frame_done,
  output logic                                    wr_bank,
  output logic                                    wr_allow,
  output logic [BANK_AW:0]                        bram_b_addr,
  output logic                                    bram_b_en,
  input  logic [CPLX_W-1:0]                       bram_b_dout,
  output logic [CPLX_W-1:0]                       m_axis_tdata,
  output logic                                    m_axis_tvalid,
  input  logic                                    m_axis_tready,
  output logic                                    m_axis_tlast,
  output logic [$clog2(NUM_MIC)+$clog2(NUM_BIN)-1:0] m_axis_tuser,
  output logic                                    overflow
`ifdef FFT_SCHED_STATS_EN
  ,
  output logic [15:0]                             frame_cnt,
  output logic [15:0]                             drop_cnt
`endif
);

  localparam int MIC_W   = $clog2(NUM_MIC);
  localparam int BIN_W   = $clog2(NUM_BIN);
  localparam int TUSER_W = MIC_W + BIN_W;
  localparam logic [MIC_W-1:0] MIC_LAST = MIC_W'(NUM_MIC - 1);
  localparam logic [BIN_W-1:0] BIN_LAST = BIN_W'(NUM_BIN - 1);

  sched_state_t       state_reg, state_next;
  logic [MIC_W-1:0]   mic_reg, mic_next;
  logic [BIN_W-1:0]   bin_reg, bin_next;
  logic               tvalid_reg;
  logic               tlast_reg;
  logic [TUSER_W-1:0] tuser_reg;
  logic               advance;
  logic               issue;
  logic               last_addr;
  logic               rd_release;
  logic               rd_bank;
  logic [1:0]         full;
  logic [BANK_AW-1:0] word_off;

  fft_bank_tracker u_tracker (
    .clk           (clk),
    .rst           (rst),
    .wr_frame_done (wr_frame_done),
    .rd_release    (rd_release),
    .wr_bank       (wr_bank),
    .rd_bank       (rd_bank),
    .full          (full),
    .wr_allow      (wr_allow),
    .overflow      (overflow)
`ifdef FFT_SCHED_STATS_EN
    ,
    .frame_cnt     (frame_cnt),
    .drop_cnt      (drop_cnt)
`endif
  );

  always_comb begin
    state_next = state_reg;
    mic_next   = mic_reg;
    bin_next   = bin_reg;
    issue      = 1'b0;
    rd_release = 1'b0;
    advance    = ~tvalid_reg | m_axis_tready;
    last_addr  = (mic_reg == MIC_LAST) && (bin_reg == BIN_LAST);
    case (state_reg)
      IDLE: begin
        if (full[rd_bank]) begin
          mic_next   = '0;
          bin_next   = '0;
          state_next = READ;
        end
      end
      READ: begin
        // A read is issued only when the output register can take its result.
        if (advance) begin
          issue = 1'b1;
          if (last_addr) begin
            state_next = DRAIN;
          end else if (mic_reg == MIC_LAST) begin
            mic_next = '0;
            bin_next = bin_reg + BIN_W'(1);
          end else begin
            mic_next = mic_reg + MIC_W'(1);
          end
        end
      end
      DRAIN: begin
        if (tvalid_reg && m_axis_tready && tlast_reg) begin
          rd_release = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      mic_reg    <= '0;
      bin_reg    <= '0;
      tvalid_reg <= 1'b0;
      tlast_reg  <= 1'b0;
      tuser_reg  <= '0;
    end else begin
      state_reg <= state_next;
      mic_reg   <= mic_next;
      bin_reg   <= bin_next;
      if (issue) begin
        tvalid_reg <= 1'b1;
        tlast_reg  <= last_addr;
        tuser_reg  <= {mic_reg, bin_reg};
      end else if (m_axis_tready) begin
        tvalid_reg <= 1'b0;
      end
    end
  end

  // Word offset within a bank is mic*NUM_BIN + bin.
  generate
    if (NUM_BIN == (1 << BIN_W)) begin : g_shift_addr
      assign word_off = BANK_AW'({mic_reg, bin_reg});
    end else begin : g_mul_addr
      assign word_off = BANK_AW'(mic_reg) * BANK_AW'(NUM_BIN) + BANK_AW'(bin_reg);
    end
  endgenerate

  assign bram_b_addr   = {rd_bank, word_off};
  assign bram_b_en     = issue;
  assign m_axis_tdata  = bram_b_dout;
  assign m_axis_tvalid = tvalid_reg;
  assign m_axis_tlast  = tlast_reg;
  assign m_axis_tuser  = tuser_reg;

endmodule

// File: doc/fft_bank_scheduler.md
Name: fft_bank_scheduler

Overview:
- Ping-pong bank controller for the FFT frame buffer, which holds NUM_MIC x NUM_BIN complex words.
- The FFT-to-BRAM writer fills one bank (port A); this block selects that bank, tracks full banks and streams completed banks out of port B to the beamformer.
- Readout is bin-major: for each bin, all mics.
- Owns bank arbitration, read addressing, backpressure and overflow reporting.

Parameters:
- NUM_MIC, 8, microphones per frame.
- NUM_BIN, 256, FFT bins per mic.
- BANK_AW, 11, address bits per bank; must satisfy 2^BANK_AW >= NUM_MIC*NUM_BIN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- wr_frame_done  in  1  one-cycle pulse: writer has finished a full frame in wr_bank.
- wr_bank  out  1  bank the writer must target; this is BRAM port-A address MSB.
- wr_allow  out  1  wr_bank is free to write.
- bram_b_addr  out  BANK_AW+1  port-B word address, {rd_bank, mic*NUM_BIN+bin}.
- bram_b_en  out  1  port-B enable; when low, BRAM holds its output.
- bram_b_dout  in  64  port-B read data {re[31:0], im[31:0]}, latency 1.
- m_axis_tdata  out  64  equals bram_b_dout.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream accept.
- m_axis_tlast  out  1  last beat of frame (bin NUM_BIN-1, mic NUM_MIC-1).
- m_axis_tuser  out  $clog2(NUM_MIC)+$clog2(NUM_BIN)  {mic, bin} of current beat.
- overflow  out  1  sticky: a frame was dropped.

Behaviour:
- Reset (asynchronous, immediate, also mid-frame): all of the following go to 0 and the state goes to IDLE:
  - wr_bank, rd_bank, full[1:0], counters, m_axis_tvalid, overflow, bram_b_en.
- Reset mid-frame discards any partially read bank.
- wr_allow = ~full[wr_bank] (combinational).

- Writer side, on wr_frame_done:
  - If wr_allow: set full[wr_bank] and toggle wr_bank.
  - Else: frame dropped. Set overflow. Leave wr_bank and full unchanged.

- State machine:
  - IDLE: if full[rd_bank], clear bin and mic counters and go to READ.
  - READ: issue reads.
    - advance = ~m_axis_tvalid | m_axis_tready.
    - bram_b_en = advance & issuing.
    - On each issued read: mic increments; when mic wraps, bin increments.
    - After issuing the final address (mic=NUM_MIC-1, bin=NUM_BIN-1), stop issuing and go to DRAIN.
  - DRAIN: wait for the last beat to be accepted (tvalid & tready & tlast). Then clear full[rd_bank], toggle rd_bank and go to IDLE.

- Output timing:
  - m_axis_tvalid is registered: set the cycle after an issued read; cleared on accept with no new issue.
  - tuser and tlast are registered alongside, so they align with the data.
  - Read latency from full-bank detect to first tvalid: 2 cycles (IDLE->READ, then BRAM latency).
  - Sustained throughput with tready=1: 1 beat/cycle.

- Address: bram_b_addr = {rd_bank, mic*NUM_BIN + bin}. The multiply is by a constant; implement it as a shift when NUM_BIN is a power of two.

- Simultaneous events:
  - wr_frame_done and release of the same bank in the same cycle: release is evaluated first, so the frame is accepted. This only applies when the writer targets the bank being freed.
  - Both banks full: the writer stalls (wr_allow=0) until the reader releases one.

- Backpressure: holding tready=0 freezes the counters, the address and BRAM dout (bram_b_en=0). No beat is lost or duplicated.

Optional Feature:
- FFT_SCHED_STATS_EN defined: add the following outputs.
  - frame_cnt [15:0]: increments on each released bank; wraps.
  - drop_cnt [15:0]: increments on each dropped frame; saturates at 16'hFFFF.
  - Both reset to 0.
- Undefined: neither port nor register exists; only the sticky overflow is reported.

Decomposition:
- Package fft_sched_pkg holds:
  - the state enum (IDLE, READ, DRAIN);
  - NUM_MIC and NUM_BIN defaults;
  - localparam widths for mic, bin and tuser;
  - the complex word width of 64.
- One natural sub-module: fft_bank_tracker, holding the full[1:0] flags, wr_bank, rd_bank, the overflow logic and the release/frame_done priority.
- Read sequencing and the AXIS output stay in the top.

Test Plan:
- Single frame: one wr_frame_done pulse, tready=1.
  - Expect 2048 beats: first tuser={0,0}, addr 0; second tuser={1,0}, addr 256.
  - Expect tlast only on beat 2048 (tuser={7,255}, addr 2047).
  - Expect wr_bank=1 afterwards and full cleared.
- Random backpressure: tready toggles with 50% probability during a frame.
  - The captured sequence must equal a golden bin-major address list with no gaps or repeats.
  - tdata must stay stable while tvalid & ~tready.
- Overflow: three wr_frame_done pulses with tready=0.
  - The first two are accepted; wr_allow=0 after the second.
  - The third sets overflow=1, and drop_cnt=1 with FFT_SCHED_STATS_EN.
- Same-cycle release and frame_done:
  - Writer pulses on the exact cycle the final tlast beat is accepted for bank 0, while bank 1 is already full and wr_bank=0.
  - Expect the frame accepted, full[0]=1 and overflow=0.
- Reset mid-frame: assert rst at beat 1000.
  - All outputs go to 0 the same cycle without waiting for clk.
  - After release, a new wr_frame_done restarts at addr 0, bank 0.
- Back-to-back frames: two frames pre-filled, tready=1.
  - Expect 4096 contiguous beats; second frame addresses start at 2048 (bank bit set).
  - Only one idle gap of 2 cycles between the frames.
